// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state codes, instruction fields and datapath mux encodings
// shared by the multicycle controller, ALU and datapath.
package multicycle_control_fsm_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXEC_R   = 5'd3,
        S_R_WB     = 5'd4,
        S_EXEC_I   = 5'd5,
        S_I_WB     = 5'd6,
        S_MEM_ADDR = 5'd7,
        S_MEM_RD   = 5'd8,
        S_MEM_WB   = 5'd9,
        S_MEM_WR   = 5'd10,
        S_BRANCH   = 5'd11,
        S_JUMP     = 5'd12,
        S_EXCEPT   = 5'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_REG = 2'b01;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [2:0] ADDR_PC     = 3'b000;
    localparam logic [2:0] ADDR_ALUOUT = 3'b001;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;

    localparam logic [3:0] WB_ALUOUT = 4'b0000;
    localparam logic [3:0] WB_MDR    = 4'b0001;

    function automatic logic funct_legal(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
        return fn == FN_SUB ? ALU_SUB :
               fn == FN_AND ? ALU_AND :
               fn == FN_OR  ? ALU_OR  :
               fn == FN_SLT ? ALU_SLT : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_wait_counter.sv
// multicycle_control_fsm_wait_counter: 4-bit memory wait-state counter; done once
// MEM_WAIT extra cycles have elapsed in the current memory state.
module multicycle_control_fsm_wait_counter #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [3:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear)
            count <= '0;
        else if (enable && !done)
            count <= count + 4'd1;
    end

    assign done = count == 4'(MEM_WAIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore controller sequencing fetch/decode/execute/memory/write-back
// for the MIPS-subset multicycle datapath, with wait states and an exception path.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT       = 1,
    parameter int          STATE_W        = 5,
    parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               Overflow,
    output logic               MemWR,
    output logic [2:0]         IorD,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [1:0]         RegDst,
    output logic [3:0]         MemToReg,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               RegWrite,
    output logic               AWrite,
    output logic               BWrite,
    output logic               ALUOutWrite,
    output logic               MDRWrite,
    output logic               EPCWrite,
    output logic [STATE_W-1:0] state
);

    state_t cur, nxt;
    logic   done;
    logic   unused_zero;

    // Branch resolution is done by PCWriteCond gating in the datapath, not here.
    assign unused_zero = Zero;

    multicycle_control_fsm_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clock  (clock),
        .reset  (reset),
        .clear  (nxt != cur),
        .enable (cur == S_FETCH || cur == S_MEM_RD || cur == S_MEM_WR),
        .done   (done)
    );

    always_ff @(posedge clock) begin
        cur <= !reset ? S_RESET : nxt;
    end

    always_comb begin
        nxt = S_RESET;
        case (cur)
            S_RESET:    nxt = S_FETCH;
            S_FETCH:    nxt = done ? S_DECODE : S_FETCH;
            S_DECODE:
                case (Opcode)
                    OP_RTYPE:     nxt = funct_legal(funct) ? S_EXEC_R : S_EXCEPT;
                    OP_ADDI:      nxt = S_EXEC_I;
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_EXCEPT;
                endcase
            S_EXEC_R:   nxt = Overflow && (funct == FN_ADD || funct == FN_SUB) ? S_EXCEPT : S_R_WB;
            S_EXEC_I:   nxt = Overflow ? S_EXCEPT : S_I_WB;
            S_MEM_ADDR: nxt = Opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   nxt = done ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   nxt = done ? S_FETCH : S_MEM_WR;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_EXCEPT: nxt = S_FETCH;
            default:    nxt = S_RESET;
        endcase
    end

    always_comb begin
        MemWR       = 1'b0;
        IorD        = ADDR_PC;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_ADD;
        PCSource    = PC_ALU;
        RegDst      = DST_RT;
        MemToReg    = WB_ALUOUT;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegWrite    = 1'b0;
        AWrite      = 1'b0;
        BWrite      = 1'b0;
        ALUOutWrite = 1'b0;
        MDRWrite    = 1'b0;
        EPCWrite    = 1'b0;
        case (cur)
            S_FETCH: begin
                IRWrite = done;
                PCWrite = done;
                ALUSrcB = done ? SRCB_FOUR : SRCB_B;
            end
            S_DECODE: begin
                AWrite      = 1'b1;
                BWrite      = 1'b1;
                ALUOutWrite = 1'b1;
                ALUSrcB     = SRCB_IMM_SH;
            end
            S_EXEC_R: begin
                ALUSrcA     = SRCA_REG;
                ALUOp       = funct_aluop(funct);
                ALUOutWrite = 1'b1;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = DST_RD;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALUSrcA     = SRCA_REG;
                ALUSrcB     = SRCB_IMM;
                ALUOutWrite = 1'b1;
            end
            S_I_WB:   RegWrite = 1'b1;
            S_MEM_RD: begin
                IorD     = ADDR_ALUOUT;
                MDRWrite = done;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = WB_MDR;
            end
            S_MEM_WR: begin
                IorD  = ADDR_ALUOUT;
                MemWR = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_REG;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
            end
            S_EXCEPT: begin
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = EXC_VECTOR_SEL;
            end
            default: ;
        endcase
    end

    assign state = STATE_W'(cur);

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised successor to the single-instruction multicycle controller for the MIPS-subset datapath.
- Moore FSM sequencing fetch, decode, execute, memory and write-back over a variable number of cycles.
- Configurable memory wait states; covers R-type add/sub/and/or/slt plus addi, lw, sw, beq and j.
- Traps illegal opcode/funct and signed overflow into an exception state that writes EPC.

Parameters:
- MEM_WAIT, 1, extra cycles a memory read or write is held before its data is valid (0..15)
- STATE_W, 5, width of the exported state code
- EXC_VECTOR_SEL, 2'b11, PCSource value selecting the exception vector

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clock
- Opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- Overflow  in  1  ALU signed-overflow flag, valid in EXEC states
- MemWR  out  1  1 = memory write
- IorD  out  3  memory address mux: 000 = PC, 001 = ALUOut
- ALUSrcA  out  2  00 = PC, 01 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, EXC_VECTOR_SEL = vector
- RegDst  out  2  00 = rt, 01 = rd
- MemToReg  out  4  0000 = ALUOut, 0001 = MDR
- IRWrite, PCWrite, PCWriteCond, RegWrite, AWrite, BWrite, ALUOutWrite, MDRWrite, EPCWrite  out  1 each  register write enables
- state  out  STATE_W  current state code, for debug

Behaviour:
- Reset: while reset == 0 at a rising edge, state <= RESET and the wait counter clears; reset overrides any state, including mid-wait.
- Reset values: all write enables and MemWR are 0; all mux selects and ALUOp are 0.
- Outputs are decoded from state only. Every enable is 1 solely in the states listed below and 0 otherwise; nothing is latched across states.
- RESET -> FETCH on the first edge with reset == 1.
- FETCH:
  - holds IorD = 000; the 4-bit wait counter counts up to MEM_WAIT.
  - on the final cycle: IRWrite = 1, PCWrite = 1, ALUSrcA = 00, ALUSrcB = 01, ALUOp = add, PCSource = 00.
  - -> DECODE. Fetch therefore takes 1 + MEM_WAIT cycles.
- DECODE:
  - AWrite = BWrite = ALUOutWrite = 1; ALUSrcA = 00, ALUSrcB = 11, add (branch target).
  - dispatch: R-type with a legal funct -> EXEC_R; 0x08 addi -> EXEC_I; 0x23/0x2B lw/sw -> MEM_ADDR; 0x04 beq -> BRANCH; 0x02 j -> JUMP; anything else -> EXCEPT.
- EXEC_R:
  - ALUSrcA = 01, ALUSrcB = 00; ALUOp from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - ALUOutWrite = 1.
  - Overflow == 1 with add/sub -> EXCEPT; else -> R_WB.
- R_WB: RegWrite = 1, RegDst = 01, MemToReg = 0000 -> FETCH.
- EXEC_I:
  - ALUSrcA = 01, ALUSrcB = 10, add, ALUOutWrite = 1.
  - Overflow -> EXCEPT; else -> I_WB.
- I_WB: RegWrite = 1, RegDst = 00, MemToReg = 0000 -> FETCH.
- MEM_ADDR: ALUSrcA = 01, ALUSrcB = 10, add, ALUOutWrite = 1 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD = 001; waits MEM_WAIT cycles, then MDRWrite = 1 on the final cycle -> MEM_WB.
- MEM_WB: RegWrite = 1, RegDst = 00, MemToReg = 0001 -> FETCH.
- MEM_WR: IorD = 001; MemWR = 1 for all 1 + MEM_WAIT cycles -> FETCH.
- BRANCH: ALUSrcA = 01, ALUSrcB = 00, sub, PCWriteCond = 1, PCSource = 01 -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
- EXCEPT:
  - EPCWrite = 1, PCWrite = 1, PCSource = EXC_VECTOR_SEL.
  - RegWrite = 0, so overflow never commits a result.
  - -> FETCH.
- Wait counter: clears on every state entry; with MEM_WAIT = 0, memory states last exactly 1 cycle.
- Undefined state code -> RESET on the next edge.

Decomposition:
- Shared package (control_pkg): state codes, opcode/funct constants, ALUOp/PCSource/ALUSrc/MemToReg encodings. The ALU and datapath import the same package.
- One sub-module, wait_counter: 4-bit, with clear, enable and done = (count == MEM_WAIT).
- Output decode stays a single combinational block inside the FSM.

Test Plan:
- Hold reset = 0 for 3 edges, then release: state = RESET, every enable 0; the next edge gives FETCH with IorD = 000.
- MEM_WAIT = 2, add (Opcode 0x00, funct 0x20), Overflow = 0: FETCH for 3 cycles, IRWrite pulses only on the 3rd; then DECODE, EXEC_R (ALUOp 000), R_WB (RegWrite = 1, RegDst = 01); FETCH re-entered 6 cycles after start.
- lw (0x23) with MEM_WAIT = 2: MDRWrite is a single 1-cycle pulse on the 3rd MEM_RD cycle; MEM_WB has MemToReg = 0001, RegDst = 00. sw (0x2B): MemWR = 1 for exactly 3 cycles, RegWrite never 1.
- beq with Zero = 1 and Zero = 0: PCWriteCond = 1, PCSource = 01, ALUOp = 001 in both runs; PCWrite stays 0 in BRANCH.
- Opcode 0x3F, then add with Overflow = 1 in EXEC_R: both reach EXCEPT with EPCWrite = PCWrite = 1, PCSource = 11, and RegWrite stays 0 throughout.
- reset = 0 asserted during the 2nd cycle of MEM_RD: next edge gives RESET with MDRWrite never asserted and the counter at 0.
